// File: rtl/wbu.sv
// wbu: writeback unit with a 2-entry result buffer, GPR file, read forwarding.
// Ports: m_* accept handshake, rs1/rs2 read ports, w_* retire info, counters.
module wbu #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      m_valid,
    output logic                      m_ready,
    input  logic                      m_regW,
    input  logic [REG_ADDR_WIDTH-1:0] m_regAddr,
    input  logic [DATA_WIDTH-1:0]     m_regData,
    input  logic                      m_halt,
    input  logic                      wb_stall,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    output logic                      w_valid,
    output logic                      w_regW,
    output logic [REG_ADDR_WIDTH-1:0] w_regAddr,
    output logic [DATA_WIDTH-1:0]     w_regData,
    output logic [CNT_WIDTH-1:0]      retire_cnt,
    output logic                      halted
);

    localparam int DEPTH = 2 ** REG_ADDR_WIDTH;

    typedef struct packed {
        logic                      regw;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
        logic                      halt;
    } ent_t;

    ent_t                  buf_q [2];
    logic                  head_q;
    logic                  tail_q;
    logic [1:0]            count_q;
    logic [DATA_WIDTH-1:0] rf_q [DEPTH];

    ent_t in_ent;
    ent_t old_ent;
    ent_t yng_ent;
    logic accept;
    logic retire;
    logic old_v;
    logic yng_v;
    logic hd_wr;

    assign m_ready = (count_q != 2'd2);
    assign accept  = m_valid && m_ready;
    assign retire  = (count_q != 2'd0) && !wb_stall && !halted;
    assign in_ent  = '{m_regW, m_regAddr, m_regData, m_halt};

    // With two entries the one after head is the younger; with one,
    // only head holds a valid entry.
    assign old_ent = buf_q[head_q];
    assign yng_ent = buf_q[~head_q];
    assign old_v   = (count_q != 2'd0);
    assign yng_v   = (count_q == 2'd2);
    assign hd_wr   = old_ent.regw && (old_ent.addr != '0);

    function automatic logic [DATA_WIDTH-1:0] fwd(
        input logic [REG_ADDR_WIDTH-1:0] a,
        input ent_t                      yng,
        input logic                      yv,
        input ent_t                      old,
        input logic                      ov,
        input logic [DATA_WIDTH-1:0]     rfv
    );
        logic [DATA_WIDTH-1:0] r;
        r = rfv;
        if (a == '0)
            r = '0;
        else if (yv && yng.regw && yng.addr == a)
            r = yng.data;
        else if (ov && old.regw && old.addr == a)
            r = old.data;
        return r;
    endfunction

    assign rs1_data = fwd(rs1_addr, yng_ent, yng_v,
                          old_ent, old_v, rf_q[rs1_addr]);
    assign rs2_data = fwd(rs2_addr, yng_ent, yng_v,
                          old_ent, old_v, rf_q[rs2_addr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (accept) begin
                buf_q[tail_q] <= in_ent;
                tail_q        <= ~tail_q;
            end
            if (retire)
                head_q <= ~head_q;
            if (accept && !retire)
                count_q <= count_q + 2'd1;
            else if (!accept && retire)
                count_q <= count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                rf_q[i] <= '0;
        end else if (retire && hd_wr) begin
            rf_q[old_ent.addr] <= old_ent.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
            halted     <= 1'b0;
            w_valid    <= 1'b0;
            w_regW     <= 1'b0;
            w_regAddr  <= '0;
            w_regData  <= '0;
        end else begin
            w_valid <= retire;
            if (retire) begin
                retire_cnt <= retire_cnt + CNT_WIDTH'(1);
                w_regW     <= hd_wr;
                w_regAddr  <= old_ent.addr;
                w_regData  <= old_ent.data;
                if (old_ent.halt)
                    halted <= 1'b1;
            end
        end
    end

endmodule
